// File: rtl/led_pattern_sequencer.sv
// LED step sequencer: plays a latched list of 2-bit LED indices with timed on/gap phases.
// Optional dark gap between steps is built only when LED_SEQ_GAP_EN is defined.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   S_IDLE | LEDs dark, waiting for i_Start
//   S_ON   | current step's LED lit for CLKS_ON cycles
//   S_GAP  | all LEDs dark for CLKS_GAP cycles (LED_SEQ_GAP_EN only)
//   S_DONE | one-cycle o_Done pulse, then back to S_IDLE
module led_pattern_sequencer #(
  parameter int CLKS_ON  = 12500000,
  parameter int CLKS_GAP = 2500000,
  parameter int MAX_LEN  = 15
) (
  input  logic                 i_Clk,
  input  logic                 i_Rst_L,
  input  logic                 i_Start,
  input  logic [3:0]           i_Length,
  input  logic [2*MAX_LEN-1:0] i_Pattern,
  output logic [3:0]           o_LED,
  output logic                 o_Busy,
  output logic                 o_Done,
  output logic [3:0]           o_Step
);

  localparam int CNT_MAX = (CLKS_ON > CLKS_GAP) ? CLKS_ON : CLKS_GAP;
  localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
  localparam logic [CNT_W-1:0] ON_LAST = CNT_W'(CLKS_ON - 1);
`ifdef LED_SEQ_GAP_EN
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(CLKS_GAP - 1);
`endif
  localparam logic [3:0] MAX_LEN_4 = 4'(MAX_LEN);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ON   = 2'd1,
`ifdef LED_SEQ_GAP_EN
    S_GAP  = 2'd3,
`endif
    S_DONE = 2'd2
  } state_t;

  state_t                 state_q;
  logic [CNT_W-1:0]       cnt_q;
  logic [2*MAX_LEN-1:0]   pat_q;
  logic [3:0]             len_q;
  logic [3:0]             step_q;
  logic [3:0]             led_q;
  logic                   busy_q;
  logic                   done_q;

  logic [3:0]             len_d;
  logic [3:0]             step_d;
  logic [1:0]             steps_w [16];

  function automatic logic [3:0] onehot(input logic [1:0] v);
    return 4'b0001 << v;
  endfunction

  // Unpack the latched pattern into a 16-entry table so a 4-bit step index never selects out of range.
  for (genvar k = 0; k < 16; k++) begin : g_steps
    if (k < MAX_LEN) begin : g_used
      assign steps_w[k] = pat_q[2*k +: 2];
    end else begin : g_unused
      assign steps_w[k] = 2'b00;
    end
  end

  always_comb begin
    len_d  = (i_Length > MAX_LEN_4) ? MAX_LEN_4 : i_Length;
    step_d = step_q + 4'd1;
  end

  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      pat_q   <= '0;
      len_q   <= 4'd0;
      step_q  <= 4'd0;
      led_q   <= 4'd0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          led_q  <= 4'd0;
          busy_q <= 1'b0;
          if (i_Start) begin
            pat_q  <= i_Pattern;
            len_q  <= len_d;
            step_q <= 4'd0;
            cnt_q  <= '0;
            if (len_d == 4'd0) begin
              state_q <= S_DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= S_ON;
              busy_q  <= 1'b1;
              led_q   <= onehot(i_Pattern[1:0]);
            end
          end
        end

        S_ON: begin
          if (cnt_q == ON_LAST) begin
            cnt_q <= '0;
            if (step_q == len_q - 4'd1) begin
              state_q <= S_DONE;
              busy_q  <= 1'b0;
              led_q   <= 4'd0;
              done_q  <= 1'b1;
            end else begin
`ifdef LED_SEQ_GAP_EN
              state_q <= S_GAP;
              led_q   <= 4'd0;
`else
              step_q  <= step_d;
              led_q   <= onehot(steps_w[step_d]);
`endif
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end

`ifdef LED_SEQ_GAP_EN
        S_GAP: begin
          if (cnt_q == GAP_LAST) begin
            cnt_q   <= '0;
            state_q <= S_ON;
            step_q  <= step_d;
            led_q   <= onehot(steps_w[step_d]);
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
`endif

        S_DONE: begin
          state_q <= S_IDLE;
          cnt_q   <= '0;
          led_q   <= 4'd0;
          busy_q  <= 1'b0;
        end

        default: begin
          state_q <= S_IDLE;
          cnt_q   <= '0;
          led_q   <= 4'd0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign o_LED  = led_q;
  assign o_Busy = busy_q;
  assign o_Done = done_q;
  assign o_Step = step_q;

endmodule

// File: doc/led_pattern_sequencer.md
# led_pattern_sequencer

Plays a stored sequence of LED steps on the four board LEDs, one LED lit per step, with programmable on-time and inter-step dark gap. It sits between the memory-game state machine and the LED outputs. The game hands over a pattern and a length with a start pulse and gets a done pulse back, so the game FSM no longer runs its own display timers. It is a pure sequencer: it owns the LED outputs while busy and drives them dark otherwise.

## Interface
- CLKS_ON, default 12500000: clock cycles each step's LED is lit (0.5 s at 25 MHz); legal ≥ 1.
- CLKS_GAP, default 2500000: clock cycles all LEDs dark between consecutive steps; legal ≥ 1.
- MAX_LEN, default 15: maximum steps; legal 1..15.

Ports:
- i_Clk  in  1  system clock; every register is on its rising edge.
- i_Rst_L  in  1  asynchronous, active-low reset.
- i_Start  in  1  start request; sampled only in IDLE.
- i_Length  in  4  number of steps to play.
- i_Pattern  in  2*MAX_LEN  flat step list; step k is i_Pattern[2k+1:2k], value v lights o_LED[v].
- o_LED  out  4  one-hot LED drive, or all zero.
- o_Busy  out  1  high while a sequence is playing.
- o_Done  out  1  one-cycle pulse when a sequence completes.
- o_Step  out  4  index of the step currently shown (0-based).

## Operation
- States: IDLE, ON, GAP, DONE.
- IDLE: o_LED=0, o_Busy=0. When i_Start=1 at an edge:
  - Latch i_Pattern and the effective length L = min(i_Length, MAX_LEN).
  - L=0: go to DONE.
  - L>0: go to ON with step=0.
- ON: o_LED = one-hot of the latched step entry, o_Busy=1. After CLKS_ON cycles:
  - Last step (step = L-1): go to DONE.
  - Otherwise: go to GAP.
- GAP: o_LED=0, o_Busy=1. After CLKS_GAP cycles, step increments and the state returns to ON.
- DONE: o_Done=1, o_Busy=0, o_LED=0 for exactly one cycle, then IDLE.
- i_Start while ON, GAP or DONE is ignored and not queued. Changes to i_Pattern or i_Length after the latch have no effect.
- One cycle counter wide enough for max(CLKS_ON, CLKS_GAP)-1. It reloads to 0 on every state entry and never wraps mid-state.
- o_Step holds its last value in DONE and resets to 0 on the next accepted start.

## Timing
- All outputs are registered.
- Reset values: o_LED=0, o_Busy=0, o_Done=0, o_Step=0, state IDLE.
- Asserting i_Rst_L low mid-sequence clears all outputs asynchronously and abandons the sequence. No o_Done is emitted.
- Start accepted at edge N: the first LED and o_Busy are visible after edge N (latency 1 cycle).
- Each ON step lasts exactly CLKS_ON cycles; each gap lasts exactly CLKS_GAP cycles.
- Total busy time is L*CLKS_ON + (L-1)*CLKS_GAP cycles. o_Done rises the cycle o_Busy falls.
- L=0: o_Done pulses in the cycle after the accepting edge; o_Busy never asserts.
- Back-to-back: i_Start held high through DONE is accepted on the first IDLE cycle, so the minimum re-start spacing is one idle cycle.

## Configuration
- Macro: LED_SEQ_GAP_EN.
- Defined: GAP state present, behaviour as above.
- Undefined: no GAP state. ON advances directly to the next step's ON, LEDs are never dark between steps, CLKS_GAP is ignored, and busy time is L*CLKS_ON.

## Test plan
- Reset: hold i_Rst_L low, toggle i_Start -> o_LED=0, o_Busy=0, o_Done=0, o_Step=0.
- Basic (CLKS_ON=4, CLKS_GAP=2, gap enabled), pattern {step0=2, step1=0, step2=3}, L=3:
  - Expect o_LED 0100×4, 0000×2, 0001×4, 0000×2, 1000×4.
  - Busy for 16 cycles, then one o_Done pulse.
  - Same stimulus with LED_SEQ_GAP_EN undefined -> busy for 12 cycles with no dark cycles.
- Boundaries:
  - L=0 -> o_Done pulses one cycle after the start edge, o_Busy stays 0.
  - i_Length=15 with MAX_LEN=6 -> exactly 6 steps play.
- Ignored inputs: pulse i_Start and change i_Pattern mid-sequence -> output unchanged, a single o_Done, no second run.
- Reset mid-sequence: pull i_Rst_L low during step 1 ON -> LEDs dark immediately, no o_Done. A new start after release plays from step 0.
